// File: rtl/fetch_ctrl_pkg.sv
// Shared fetch-stage types: FSM state, the nop encoding and the IF/ID record.
package fetch_ctrl_pkg;

  typedef enum logic [1:0] {
    S_REQ      = 2'd0,
    S_HOLD     = 2'd1,
    S_IDLE_MIS = 2'd2
  } fetch_state_t;

  localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

  typedef struct packed {
    logic        valid;
    logic [63:0] pc;
    logic [31:0] instr;
    logic        misalign;
  } if_id_t;

  function automatic logic pc_misaligned(input logic [63:0] pc);
    return pc[1:0] != 2'b00;
  endfunction

endpackage

// File: rtl/fetch_ctrl.sv
// Fetch-stage sequencer: owns the PC, issues ibus reads, holds the fetched
// word for decode under stall and kills stale fetches on redirect.
//
//   state      | meaning
//   -----------+----------------------------------------------------------
//   S_REQ      | read of pc_cur on the bus (idle for one cycle after reset)
//   S_HOLD     | fetched word held for decode while stall is high
//   S_IDLE_MIS | pc_cur misaligned: fault presented until redirect
module fetch_ctrl
  import fetch_ctrl_pkg::*;
#(
  parameter logic [63:0] RESET_PC = 64'h8000_0000
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic [63:0] pc_nxt_i,
  input  logic        redirect_i,
  input  logic        stall_i,
  output logic [63:0] pc_cur_o,
  output logic        ireq_valid_o,
  output logic [63:0] ireq_addr_o,
  input  logic        iresp_data_ok_i,
  input  logic [31:0] iresp_data_i,
  output logic        if_valid_o,
  output logic [63:0] if_pc_o,
  output logic [31:0] if_instr_o,
  output logic        if_misalign_o
);

  fetch_state_t state_q;
  logic [63:0]  pc_q;
  logic [63:0]  tgt_q;
  logic         kill_q;
  logic         req_q;
  if_id_t       hold_q;

  logic         rsp_ok;
  logic         live;
  logic         enter_en;
  logic [63:0]  enter_pc;

  assign rsp_ok = (state_q == S_REQ) & req_q & iresp_data_ok_i;
  // A response is forwarded straight to decode only if it is not stale.
  assign live   = rsp_ok & ~kill_q & ~redirect_i;

  // Decide whether the PC moves this cycle, and to where.
  always_comb begin
    enter_en = 1'b0;
    enter_pc = pc_q;
    unique case (state_q)
      S_REQ: begin
        if (!req_q) begin
          // post-reset idle cycle: start fetching (or redirect) next cycle
          enter_en = 1'b1;
          enter_pc = redirect_i ? pc_nxt_i : pc_q;
        end else if (iresp_data_ok_i) begin
          if (redirect_i) begin
            enter_en = 1'b1;
            enter_pc = pc_nxt_i;
          end else if (kill_q) begin
            enter_en = 1'b1;
            enter_pc = tgt_q;
          end else if (!stall_i) begin
            enter_en = 1'b1;
            enter_pc = pc_nxt_i;
          end
        end
      end
      S_HOLD: begin
        if (redirect_i || !stall_i) begin
          enter_en = 1'b1;
          enter_pc = pc_nxt_i;
        end
      end
      S_IDLE_MIS: begin
        if (redirect_i) begin
          enter_en = 1'b1;
          enter_pc = pc_nxt_i;
        end
      end
      default: begin
        enter_en = 1'b1;
        enter_pc = pc_q;
      end
    endcase
  end

  // Fetch FSM with PC, kill/target and IF/ID hold registers.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= S_REQ;
      pc_q    <= RESET_PC;
      tgt_q   <= '0;
      kill_q  <= 1'b0;
      req_q   <= 1'b0;
      hold_q  <= '0;
    end else if (enter_en) begin
      pc_q   <= enter_pc;
      kill_q <= 1'b0;
      if (pc_misaligned(enter_pc)) begin
        state_q <= S_IDLE_MIS;
        req_q   <= 1'b0;
        hold_q  <= '{1'b1, enter_pc, NOP_INSTR, 1'b1};
      end else begin
        state_q      <= S_REQ;
        req_q        <= 1'b1;
        hold_q.valid <= 1'b0;
      end
    end else if (state_q == S_REQ && req_q) begin
      if (iresp_data_ok_i) begin
        // only a live response under stall reaches here
        state_q <= S_HOLD;
        req_q   <= 1'b0;
        hold_q  <= '{1'b1, pc_q, iresp_data_i, 1'b0};
      end else if (redirect_i) begin
        kill_q <= 1'b1;
        tgt_q  <= pc_nxt_i;
      end
    end
  end

  // Present either the live bus response or the held IF/ID record.
  always_comb begin
    if_valid_o    = 1'b0;
    if_pc_o       = hold_q.pc;
    if_instr_o    = hold_q.instr;
    if_misalign_o = 1'b0;
    if (live) begin
      if_valid_o = 1'b1;
      if_pc_o    = pc_q;
      if_instr_o = iresp_data_i;
    end else begin
      if_valid_o    = hold_q.valid & ~redirect_i;
      if_misalign_o = hold_q.misalign & hold_q.valid & ~redirect_i;
    end
  end

  assign pc_cur_o     = pc_q;
  assign ireq_valid_o = req_q;
  assign ireq_addr_o  = pc_q;

endmodule

// File: tb/tb_fetch_ctrl.sv
// Self-checking bench for fetch_ctrl: directed vector table, reset corner
// case, then randomized traffic against a transaction-level model.
module tb_fetch_ctrl;

  localparam logic [63:0] RST_PC = 64'h8000_0000;
  localparam logic [31:0] NOP    = 32'h0000_0013;

  logic        clk;
  logic        rst_n;
  logic [63:0] pc_nxt;
  logic        redirect;
  logic        stall;
  logic [63:0] pc_cur;
  logic        ireq_valid;
  logic [63:0] ireq_addr;
  logic        data_ok;
  logic [31:0] data;
  logic        if_valid;
  logic [63:0] if_pc;
  logic [31:0] if_instr;
  logic        if_misalign;

  int n_chk  = 0;
  int n_fail = 0;

  fetch_ctrl #(.RESET_PC(RST_PC)) dut (
    .clk_i(clk), .rst_ni(rst_n), .pc_nxt_i(pc_nxt), .redirect_i(redirect),
    .stall_i(stall), .pc_cur_o(pc_cur), .ireq_valid_o(ireq_valid),
    .ireq_addr_o(ireq_addr), .iresp_data_ok_i(data_ok), .iresp_data_i(data),
    .if_valid_o(if_valid), .if_pc_o(if_pc), .if_instr_o(if_instr),
    .if_misalign_o(if_misalign)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] dat(input logic [63:0] a);
    return a[31:0] ^ 32'h1357_9BDF;
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
    end
  endtask

  typedef struct {
    logic        r;
    logic [63:0] nxt;
    logic        st;
    logic        ok;
    logic [31:0] d;
    logic        e_req;
    logic [63:0] e_addr;
    logic [63:0] e_pc;
    logic        e_ifv;
    logic [63:0] e_ifpc;
    logic [31:0] e_instr;
    logic        e_mis;
  } vec_t;

  function automatic vec_t mk(input logic r, input logic [63:0] nxt, input logic st,
                              input logic ok, input logic [31:0] d, input logic e_req,
                              input logic [63:0] e_addr, input logic [63:0] e_pc,
                              input logic e_ifv, input logic [63:0] e_ifpc,
                              input logic [31:0] e_instr, input logic e_mis);
    vec_t v;
    v.r = r; v.nxt = nxt; v.st = st; v.ok = ok; v.d = d;
    v.e_req = e_req; v.e_addr = e_addr; v.e_pc = e_pc; v.e_ifv = e_ifv;
    v.e_ifpc = e_ifpc; v.e_instr = e_instr; v.e_mis = e_mis;
    return v;
  endfunction

  // ---------------- reference model (fetch transactions) ----------------
  logic [63:0] m_pc, m_tgt;
  logic [31:0] m_word;
  bit          m_first, m_busy, m_stale, m_have, m_fault;

  task automatic m_reset();
    m_pc = RST_PC; m_tgt = '0; m_word = '0;
    m_first = 1; m_busy = 0; m_stale = 0; m_have = 0; m_fault = 0;
  endtask

  // Start fetching from address a (or fault on it if it is misaligned).
  task automatic m_goto(input logic [63:0] a);
    m_pc = a; m_first = 0; m_stale = 0; m_have = 0;
    m_fault = (a[1:0] != 2'b00);
    m_busy  = !m_fault;
  endtask

  task automatic m_check();
    bit deliver, show;
    deliver = m_busy && data_ok && !m_stale && !redirect;
    show    = (m_have || m_fault) && !redirect;
    chk("pc_cur", pc_cur, m_pc);
    chk("ireq_valid", {63'd0, ireq_valid}, {63'd0, m_busy});
    if (m_busy) chk("ireq_addr", ireq_addr, m_pc);
    chk("if_valid", {63'd0, if_valid}, {63'd0, deliver || show});
    if (deliver || show) begin
      chk("if_pc", if_pc, m_pc);
      chk("if_instr", {32'd0, if_instr}, {32'd0, deliver ? data : (m_fault ? NOP : m_word)});
      chk("if_misalign", {63'd0, if_misalign}, {63'd0, show && m_fault});
    end
  endtask

  task automatic m_step();
    if (m_first)           m_goto(redirect ? pc_nxt : m_pc);
    else if (m_fault)      begin if (redirect) m_goto(pc_nxt); end
    else if (m_have)       begin if (redirect || !stall) m_goto(pc_nxt); end
    else if (m_busy) begin
      if (data_ok) begin
        if (redirect)      m_goto(pc_nxt);
        else if (m_stale)  m_goto(m_tgt);
        else if (!stall)   m_goto(pc_nxt);
        else begin m_have = 1; m_word = data; m_busy = 0; end
      end else if (redirect) begin
        m_stale = 1; m_tgt = pc_nxt;
      end
    end
  endtask

  vec_t tbl[19];

  initial begin
    tbl[0]  = mk(0, 64'h0,           0, 0, 32'h0,              0, 64'h0,           RST_PC,          0, 64'h0, 32'h0, 0);
    tbl[1]  = mk(0, 64'h0,           0, 0, 32'h0,              1, RST_PC,          RST_PC,          0, 64'h0, 32'h0, 0);
    tbl[2]  = mk(0, 64'h0,           0, 0, 32'h0,              1, RST_PC,          RST_PC,          0, 64'h0, 32'h0, 0);
    tbl[3]  = mk(0, 64'h8000_0004,   0, 1, dat(64'h8000_0000), 1, RST_PC,          RST_PC,          1, RST_PC, dat(64'h8000_0000), 0);
    tbl[4]  = mk(0, 64'h0,           1, 1, dat(64'h8000_0004), 1, 64'h8000_0004,   64'h8000_0004,   1, 64'h8000_0004, dat(64'h8000_0004), 0);
    tbl[5]  = mk(0, 64'h0,           1, 0, 32'h0,              0, 64'h0,           64'h8000_0004,   1, 64'h8000_0004, dat(64'h8000_0004), 0);
    tbl[6]  = mk(0, 64'h0,           1, 0, 32'h0,              0, 64'h0,           64'h8000_0004,   1, 64'h8000_0004, dat(64'h8000_0004), 0);
    tbl[7]  = mk(0, 64'h8000_0008,   0, 0, 32'h0,              0, 64'h0,           64'h8000_0004,   1, 64'h8000_0004, dat(64'h8000_0004), 0);
    tbl[8]  = mk(1, 64'h8000_0100,   0, 0, 32'h0,              1, 64'h8000_0008,   64'h8000_0008,   0, 64'h0, 32'h0, 0);
    tbl[9]  = mk(0, 64'h8000_000C,   0, 1, dat(64'h8000_0008), 1, 64'h8000_0008,   64'h8000_0008,   0, 64'h0, 32'h0, 0);
    tbl[10] = mk(1, 64'h8000_0200,   0, 0, 32'h0,              1, 64'h8000_0100,   64'h8000_0100,   0, 64'h0, 32'h0, 0);
    tbl[11] = mk(1, 64'h8000_0300,   0, 0, 32'h0,              1, 64'h8000_0100,   64'h8000_0100,   0, 64'h0, 32'h0, 0);
    tbl[12] = mk(0, 64'h8000_0104,   0, 1, dat(64'h8000_0100), 1, 64'h8000_0100,   64'h8000_0100,   0, 64'h0, 32'h0, 0);
    tbl[13] = mk(1, 64'h8000_0102,   0, 1, dat(64'h8000_0300), 1, 64'h8000_0300,   64'h8000_0300,   0, 64'h0, 32'h0, 0);
    tbl[14] = mk(0, 64'h0,           1, 0, 32'h0,              0, 64'h0,           64'h8000_0102,   1, 64'h8000_0102, NOP, 1);
    tbl[15] = mk(0, 64'h0,           0, 0, 32'h0,              0, 64'h0,           64'h8000_0102,   1, 64'h8000_0102, NOP, 1);
    tbl[16] = mk(1, 64'h8000_0000,   0, 0, 32'h0,              0, 64'h0,           64'h8000_0102,   0, 64'h0, 32'h0, 0);
    tbl[17] = mk(0, 64'h0,           0, 0, 32'h0,              1, RST_PC,          RST_PC,          0, 64'h0, 32'h0, 0);
    tbl[18] = mk(0, 64'h0,           0, 0, 32'h0,              1, RST_PC,          RST_PC,          0, 64'h0, 32'h0, 0);

    rst_n = 1'b0; pc_nxt = '0; redirect = 0; stall = 0; data_ok = 0; data = '0;
    #12;
    chk("reset_ireq_valid", {63'd0, ireq_valid}, 64'd0);
    chk("reset_pc_cur", pc_cur, RST_PC);
    chk("reset_if_valid", {63'd0, if_valid}, 64'd0);
    chk("reset_if_pc", if_pc, 64'd0);
    chk("reset_if_instr", {32'd0, if_instr}, 64'd0);
    chk("reset_if_misalign", {63'd0, if_misalign}, 64'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;

    // directed vectors, one row per cycle
    for (int i = 0; i < 19; i++) begin
      redirect = tbl[i].r; pc_nxt = tbl[i].nxt; stall = tbl[i].st;
      data_ok = tbl[i].ok; data = tbl[i].d;
      #4;
      chk($sformatf("vec%0d_ireq_valid", i), {63'd0, ireq_valid}, {63'd0, tbl[i].e_req});
      if (tbl[i].e_req) chk($sformatf("vec%0d_ireq_addr", i), ireq_addr, tbl[i].e_addr);
      chk($sformatf("vec%0d_pc_cur", i), pc_cur, tbl[i].e_pc);
      chk($sformatf("vec%0d_if_valid", i), {63'd0, if_valid}, {63'd0, tbl[i].e_ifv});
      if (tbl[i].e_ifv) begin
        chk($sformatf("vec%0d_if_pc", i), if_pc, tbl[i].e_ifpc);
        chk($sformatf("vec%0d_if_instr", i), {32'd0, if_instr}, {32'd0, tbl[i].e_instr});
        chk($sformatf("vec%0d_if_misalign", i), {63'd0, if_misalign}, {63'd0, tbl[i].e_mis});
      end
      @(posedge clk); #1;
    end

    // reset asserted mid-request (row 18 left a request on the bus)
    redirect = 0; stall = 0; data_ok = 0; data = '0;
    #2;
    chk("midreq_pre_ireq_valid", {63'd0, ireq_valid}, 64'd1);
    rst_n = 1'b0;
    #1;
    chk("midreq_ireq_valid", {63'd0, ireq_valid}, 64'd0);
    chk("midreq_pc_cur", pc_cur, RST_PC);
    chk("midreq_if_valid", {63'd0, if_valid}, 64'd0);
    chk("midreq_if_pc", if_pc, 64'd0);
    @(posedge clk); @(posedge clk); #1;
    rst_n = 1'b1;
    #4;
    chk("post_reset_idle", {63'd0, ireq_valid}, 64'd0);
    @(posedge clk); #1;
    chk("post_reset_req", {63'd0, ireq_valid}, 64'd1);
    chk("post_reset_addr", ireq_addr, RST_PC);

    // randomized traffic against the model
    rst_n = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    m_reset();
    for (int c = 0; c < 4000; c++) begin
      logic [63:0] tgt;
      int sel;
      redirect = ($urandom_range(0, 99) < (m_fault ? 40 : 10));
      sel = $urandom_range(0, 15);
      if (sel == 0)      tgt = 64'hFFFF_FFFF_FFFF_FFF8;
      else if (sel == 1) tgt = RST_PC + 64'($urandom_range(0, 255)) * 4 + 64'($urandom_range(1, 3));
      else               tgt = RST_PC + 64'($urandom_range(0, 255)) * 4;
      pc_nxt  = redirect ? tgt : m_pc + 64'd4;
      stall   = ($urandom_range(0, 2) == 0);
      data_ok = ireq_valid && ($urandom_range(0, 2) == 0);
      data    = dat(ireq_addr);
      #4;
      m_check();
      m_step();
      @(posedge clk); #1;
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
